sobel_window_buffer: RTL

SOBEL_WINDOW_BUFFER -- requirements
Module: sobel_window_buffer

---
 rtl/sobel_pkg.sv | 27 ++
 rtl/sobel_line_buffer.sv | 35 +++
 rtl/sobel_window_buffer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sobel_pkg
// Description : Shared FSM encoding and 3x3 window packing helpers for the
//               Sobel window buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package sobel_pkg;

  // Frame-level controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int WIN_DIM   = 3;
  localparam int WIN_ELEMS = WIN_DIM * WIN_DIM;

  // Bit offset of window element (i,j) in the packed window bus
  // (i = row from top, j = column from left).
  function automatic int win_off(input int i, input int j, input int pix_w);
    return (WIN_DIM * i + j) * pix_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sobel_line_buffer
// Description : One image line of pixel storage. Combinational read at the
//               current address, synchronous write; a read and write to the
//               same address in one cycle returns the old contents.
//               Storage is intentionally not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_line_buffer #(
  parameter int DEPTH  = 5,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read-before-write: the read path sees the pre-edge contents
  assign rdata = mem[addr];

  // Store the incoming line value at the accept address
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sobel_window_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sobel_window_buffer
// Description : Streams a raster-order frame and emits a 3x3 pixel window
//               for every pixel with row >= 2 and col >= 2. Two line
//               buffers hold the previous two rows; a 3x3 register array
//               shifts left by one column per accepted pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_window_buffer
  import sobel_pkg::*;
#(
  parameter int IMG_W = 5,
  parameter int IMG_H = 5,
  parameter int PIX_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [PIX_W-1:0]         in_pixel,
  output logic                     in_ready,
  output logic                     win_valid,
  output logic [9*PIX_W-1:0]       win_data,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(2);
  localparam logic [COL_W-1:0] COL_MIN  = COL_W'(2);

  state_t state, state_nxt;

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             accept;
  logic             last_pix;
  logic             emit;

  logic [PIX_W-1:0] lb0_rd;
  logic [PIX_W-1:0] lb1_rd;

  logic [PIX_W-1:0] win_q   [WIN_DIM][WIN_DIM];
  logic [PIX_W-1:0] win_nxt [WIN_DIM][WIN_DIM];
  logic [9*PIX_W-1:0] win_flat;

  assign in_ready   = (state == ST_STREAM);
  assign busy       = (state == ST_STREAM);
  assign frame_done = (state == ST_DONE);
  assign accept     = in_valid && in_ready;
  assign last_pix   = (row == ROW_LAST) && (col == COL_LAST);
  assign emit       = accept && (row >= ROW_MIN) && (col >= COL_MIN);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE waits for start, STREAM ends on the final pixel,
  // DONE lasts exactly one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_STREAM;
      ST_STREAM: if (accept && last_pix) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Raster position of the next pixel to be accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (state == ST_IDLE && start) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Older line: receives what the newer line held at this column
  sobel_line_buffer #(
    .DEPTH  (IMG_W),
    .WIDTH  (PIX_W),
    .ADDR_W (COL_W)
  ) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  // Newer line: receives the incoming pixel
  sobel_line_buffer #(
    .DEPTH  (IMG_W),
    .WIDTH  (PIX_W),
    .ADDR_W (COL_W)
  ) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (in_pixel),
    .rdata (lb0_rd)
  );

  // Window after a shift: columns move left, new right column enters
  // from the line buffers and the incoming pixel
  always_comb begin
    win_nxt = win_q;
    for (int i = 0; i < WIN_DIM; i++) begin
      win_nxt[i][0] = win_q[i][1];
      win_nxt[i][1] = win_q[i][2];
    end
    win_nxt[0][2] = lb1_rd;
    win_nxt[1][2] = lb0_rd;
    win_nxt[2][2] = in_pixel;
  end

  // Pack the shifted window onto the output bus layout
  generate
    for (genvar gi = 0; gi < WIN_DIM; gi++) begin : g_pack_row
      for (genvar gj = 0; gj < WIN_DIM; gj++) begin : g_pack_col
        assign win_flat[win_off(gi, gj, PIX_W) +: PIX_W] = win_nxt[gi][gj];
      end
    end
  endgenerate

  // Sliding window registers advance on every accepted pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_DIM; i++) begin
        for (int j = 0; j < WIN_DIM; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else if (accept) begin
      win_q <= win_nxt;
    end
  end

  // Output stage: capture the window one cycle after a qualifying accept,
  // hold it otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_data  <= '0;
      win_row   <= '0;
      win_col   <= '0;
    end else begin
      win_valid <= emit;
      if (emit) begin
        win_data <= win_flat;
        win_row  <= row;
        win_col  <= col;
      end
    end
  end

endmodule
`default_nettype wire
